boot_copier: RTL and testbench

- Wishbone bus master directly upstream of the boot ROM.
- After reset, or on command, copies a block of 32-bit words from ROM space into RAM, holding the CPU in reset until the copy completes, then releases it.
- Sits between the ROM/RAM slaves and the CPU reset tree in the SoC top level; shares the system bus through the arbiter as a normal master.

---
 rtl/boot_copier_pkg.sv | 19 +
 rtl/boot_copier.sv | 253 +++++++++++++++++++++++++
 tb/tb_boot_copier.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot copier: copy FSM state encoding,
// SoC memory map bases for the boot ROM and main RAM, and the
// byte-select pattern used for full-word writes.
package boot_copier_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      GAP  = 3'd2,
      WR   = 3'd3,
      NXT  = 3'd4,
      DONE = 3'd5
   } copyState_t;

   localparam logic [31:0] ROM_BASE = 32'hFFFC0000;
   localparam logic [31:0] RAM_BASE = 32'h00000000;
   localparam logic [3:0]  SEL_ALL  = 4'hF;

endpackage

// File: rtl/boot_copier.sv
// Boot copier: Wishbone master that copies WORDS 32-bit words from the
// boot ROM into RAM after reset (or on start_i), holding the CPU in
// reset until the copy has finished.
// Optional feature macro: BOOT_COPIER_TIMEOUT_EN adds an ack timeout
// that aborts the copy with err_o set and the CPU still held.
module boot_copier
   import boot_copier_pkg::*;
#(
   parameter logic [31:0] SRC_BASE   = ROM_BASE,
   parameter int unsigned SRC_STEP   = 2,
   parameter logic [31:0] DST_BASE   = RAM_BASE,
   parameter int unsigned DST_STEP   = 4,
   parameter int unsigned WORDS      = 1024,
   parameter int unsigned AUTO_START = 1,
   parameter int unsigned TO_CYCLES  = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [3:0]  sel_o,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   input  logic        ack_i,
   input  logic [31:0] dat_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        cpu_rst_o,
   output logic [15:0] count_o
);

   localparam logic [15:0] WORDS_CNT = 16'(WORDS);

   copyState_t  r_state,   w_nextState;
   logic [31:0] r_src,     w_nextSrc;
   logic [31:0] r_dst,     w_nextDst;
   logic [31:0] r_buf,     w_nextBuf;
   logic [15:0] r_count,   w_nextCount;
   logic        r_cyc,     w_nextCyc;
   logic        r_stb,     w_nextStb;
   logic        r_we,      w_nextWe;
   logic [3:0]  r_sel,     w_nextSel;
   logic [31:0] r_adr,     w_nextAdr;
   logic [31:0] r_dat,     w_nextDat;
   logic        r_busy,    w_nextBusy;
   logic        r_done,    w_nextDone;
   logic        r_err,     w_nextErr;
   logic        r_cpuRst,  w_nextCpuRst;
   logic        r_autoPend, w_nextAutoPend;

`ifdef BOOT_COPIER_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
   logic [15:0] r_waitCnt, w_nextWait;
`endif

   // Next-state and next-output logic; every bus output is registered so
   // the strobe drops on the same edge that accepts the ack.
   always_comb begin
      w_nextState    = r_state;
      w_nextSrc      = r_src;
      w_nextDst      = r_dst;
      w_nextBuf      = r_buf;
      w_nextCount    = r_count;
      w_nextCyc      = r_cyc;
      w_nextStb      = r_stb;
      w_nextWe       = r_we;
      w_nextSel      = r_sel;
      w_nextAdr      = r_adr;
      w_nextDat      = r_dat;
      w_nextBusy     = r_busy;
      w_nextDone     = r_done;
      w_nextErr      = r_err;
      w_nextCpuRst   = r_cpuRst;
      w_nextAutoPend = r_autoPend;
`ifdef BOOT_COPIER_TIMEOUT_EN
      w_nextWait     = r_waitCnt;
`endif

      case (r_state)
         IDLE, DONE: begin
            w_nextState = IDLE;
            if (start_i || r_autoPend) begin
               w_nextAutoPend = 1'b0;
               w_nextSrc      = SRC_BASE;
               w_nextDst      = DST_BASE;
               w_nextCount    = 16'd0;
               w_nextDone     = 1'b0;
               w_nextErr      = 1'b0;
               w_nextCpuRst   = 1'b1;
               if (WORDS == 0) begin
                  w_nextState  = DONE;
                  w_nextDone   = 1'b1;
                  w_nextCpuRst = 1'b0;
                  w_nextBusy   = 1'b0;
               end else begin
                  w_nextState = RD;
                  w_nextBusy  = 1'b1;
                  w_nextCyc   = 1'b1;
                  w_nextStb   = 1'b1;
                  w_nextWe    = 1'b0;
                  w_nextSel   = 4'h0;
                  w_nextAdr   = SRC_BASE;
`ifdef BOOT_COPIER_TIMEOUT_EN
                  w_nextWait  = 16'd0;
`endif
               end
            end
         end

         RD: begin
            if (ack_i) begin
               w_nextBuf   = dat_i;
               w_nextCyc   = 1'b0;
               w_nextStb   = 1'b0;
               w_nextState = GAP;
            end
`ifdef BOOT_COPIER_TIMEOUT_EN
            else if (r_waitCnt == TO_LAST) begin
               w_nextCyc   = 1'b0;
               w_nextStb   = 1'b0;
               w_nextErr   = 1'b1;
               w_nextBusy  = 1'b0;
               w_nextState = DONE;
            end else begin
               w_nextWait = r_waitCnt + 16'd1;
            end
`endif
         end

         GAP: begin
            w_nextState = WR;
            w_nextCyc   = 1'b1;
            w_nextStb   = 1'b1;
            w_nextWe    = 1'b1;
            w_nextSel   = SEL_ALL;
            w_nextAdr   = r_dst;
            w_nextDat   = r_buf;
`ifdef BOOT_COPIER_TIMEOUT_EN
            w_nextWait  = 16'd0;
`endif
         end

         WR: begin
            if (ack_i) begin
               w_nextCyc   = 1'b0;
               w_nextStb   = 1'b0;
               w_nextWe    = 1'b0;
               w_nextSel   = 4'h0;
               w_nextCount = r_count + 16'd1;
               w_nextSrc   = r_src + 32'(SRC_STEP);
               w_nextDst   = r_dst + 32'(DST_STEP);
               w_nextState = NXT;
            end
`ifdef BOOT_COPIER_TIMEOUT_EN
            else if (r_waitCnt == TO_LAST) begin
               w_nextCyc   = 1'b0;
               w_nextStb   = 1'b0;
               w_nextWe    = 1'b0;
               w_nextSel   = 4'h0;
               w_nextErr   = 1'b1;
               w_nextBusy  = 1'b0;
               w_nextState = DONE;
            end else begin
               w_nextWait = r_waitCnt + 16'd1;
            end
`endif
         end

         NXT: begin
            if (r_count == WORDS_CNT) begin
               w_nextState  = DONE;
               w_nextDone   = 1'b1;
               w_nextCpuRst = 1'b0;
               w_nextBusy   = 1'b0;
            end else begin
               w_nextState = RD;
               w_nextCyc   = 1'b1;
               w_nextStb   = 1'b1;
               w_nextAdr   = r_src;
`ifdef BOOT_COPIER_TIMEOUT_EN
               w_nextWait  = 16'd0;
`endif
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and output registers; reset releases the bus immediately and
   // re-arms the automatic start.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= IDLE;
         r_src      <= 32'h0;
         r_dst      <= 32'h0;
         r_buf      <= 32'h0;
         r_count    <= 16'h0;
         r_cyc      <= 1'b0;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_sel      <= 4'h0;
         r_adr      <= 32'h0;
         r_dat      <= 32'h0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cpuRst   <= 1'b1;
         r_autoPend <= (AUTO_START != 0);
`ifdef BOOT_COPIER_TIMEOUT_EN
         r_waitCnt  <= 16'h0;
`endif
      end else begin
         r_state    <= w_nextState;
         r_src      <= w_nextSrc;
         r_dst      <= w_nextDst;
         r_buf      <= w_nextBuf;
         r_count    <= w_nextCount;
         r_cyc      <= w_nextCyc;
         r_stb      <= w_nextStb;
         r_we       <= w_nextWe;
         r_sel      <= w_nextSel;
         r_adr      <= w_nextAdr;
         r_dat      <= w_nextDat;
         r_busy     <= w_nextBusy;
         r_done     <= w_nextDone;
         r_err      <= w_nextErr;
         r_cpuRst   <= w_nextCpuRst;
         r_autoPend <= w_nextAutoPend;
`ifdef BOOT_COPIER_TIMEOUT_EN
         r_waitCnt  <= w_nextWait;
`endif
      end
   end

   assign cyc_o     = r_cyc;
   assign stb_o     = r_stb;
   assign we_o      = r_we;
   assign sel_o     = r_sel;
   assign adr_o     = r_adr;
   assign dat_o     = r_dat;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign cpu_rst_o = r_cpuRst;
   assign count_o   = r_count;

endmodule

// File: tb/tb_boot_copier.sv
// Testbench for boot_copier: a 4-word copy instance with a ROM/RAM slave
// model, a WORDS=0 instance, and an instance whose slave never acks
// (timeout behaviour depends on BOOT_COPIER_TIMEOUT_EN).
module tb_boot_copier;

   localparam logic [31:0] SRC_BASE = 32'hFFFC0000;
   localparam logic [31:0] DST_BASE = 32'h00000000;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } wrExp_t;

   typedef struct {
      int waits;
      int expDone;
   } runVec_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic start_i = 1'b0;

   logic        cyc, stb, we, ack, busy, done, err, cpuRst;
   logic [3:0]  sel;
   logic [31:0] adr, datO, datI;
   logic [15:0] count;

   logic        zCyc, zStb, zWe, zBusy, zDone, zErr, zCpuRst;
   logic [3:0]  zSel;
   logic [31:0] zAdr, zDatO;
   logic [15:0] zCount;

   logic        tCyc, tStb, tWe, tBusy, tDone, tErr, tCpuRst;
   logic [3:0]  tSel;
   logic [31:0] tAdr, tDatO;
   logic [15:0] tCount;

   int total = 0;
   int bad = 0;
   int cycleCnt;
   int waitStates = 0;
   int slvCnt;
   int lowRun = 0;
   bit zCycSeen = 1'b0;
   wrExp_t expQ[$];

   boot_copier #(.WORDS(4), .AUTO_START(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .cyc_o(cyc), .stb_o(stb), .we_o(we), .sel_o(sel), .adr_o(adr), .dat_o(datO),
      .ack_i(ack), .dat_i(datI),
      .busy_o(busy), .done_o(done), .err_o(err), .cpu_rst_o(cpuRst), .count_o(count)
   );

   boot_copier #(.WORDS(0), .AUTO_START(1)) dutZero (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(1'b0),
      .cyc_o(zCyc), .stb_o(zStb), .we_o(zWe), .sel_o(zSel), .adr_o(zAdr), .dat_o(zDatO),
      .ack_i(1'b0), .dat_i(32'h0),
      .busy_o(zBusy), .done_o(zDone), .err_o(zErr), .cpu_rst_o(zCpuRst), .count_o(zCount)
   );

   boot_copier #(.WORDS(4), .AUTO_START(1), .TO_CYCLES(8)) dutTo (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(1'b0),
      .cyc_o(tCyc), .stb_o(tStb), .we_o(tWe), .sel_o(tSel), .adr_o(tAdr), .dat_o(tDatO),
      .ack_i(1'b0), .dat_i(32'h0),
      .busy_o(tBusy), .done_o(tDone), .err_o(tErr), .cpu_rst_o(tCpuRst), .count_o(tCount)
   );

   // 100 MHz system clock
   always #5 clk_i = ~clk_i;

   // Clocks since reset release; the first post-reset edge is clock 1
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) cycleCnt <= 0;
      else        cycleCnt <= cycleCnt + 1;
   end

   // ROM/RAM slave: registered ack after waitStates extra clocks, ROM returns its address as data
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack    <= 1'b0;
         slvCnt <= 0;
         datI   <= 32'h0;
      end else if (cyc && stb && !ack) begin
         if (slvCnt >= waitStates) begin
            ack    <= 1'b1;
            slvCnt <= 0;
            if (!we) datI <= adr;
         end else begin
            slvCnt <= slvCnt + 1;
         end
      end else begin
         ack <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Scoreboard: each accepted RAM write is popped against the expected queue;
   // also the bus must idle exactly one clock between a read and its write
   always @(negedge clk_i) begin
      if (rst_i) begin
         if (cyc && stb && we && ack) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected write", 128'(1), 128'(0));
            end else begin
               wrExp_t e;
               e = expQ.pop_front();
               checkOutput("write adr", 128'(adr), 128'(e.adr));
               checkOutput("write dat", 128'(datO), 128'(e.dat));
               checkOutput("write sel", 128'(sel), 128'(4'hF));
            end
         end
         if (!cyc) begin
            lowRun++;
         end else begin
            if (lowRun > 0 && we) checkOutput("gap before write", 128'(lowRun), 128'(1));
            lowRun = 0;
         end
         if (zCyc) zCycSeen = 1'b1;
      end
   end

   task automatic pushCopy();
      for (int i = 0; i < 4; i++) begin
         wrExp_t e;
         e.adr = DST_BASE + 32'(4 * i);
         e.dat = SRC_BASE + 32'(2 * i);
         expQ.push_back(e);
      end
   endtask

   task automatic waitCycle(input int n);
      while (cycleCnt < n) @(negedge clk_i);
   endtask

   task automatic waitDone(output int doneAt, output bit ok);
      ok = 1'b0;
      doneAt = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         if (done) begin
            ok = 1'b1;
            doneAt = cycleCnt;
            return;
         end
      end
   endtask

   // Reset everything, check reset values, arm the scoreboard and release reset
   task automatic applyStimulus(input int waits);
      @(negedge clk_i);
      rst_i = 1'b0;
      waitStates = waits;
      expQ.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("reset outputs",
                  128'({cyc, stb, we, sel, adr, datO, busy, done, err, cpuRst, count}),
                  128'({1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0}));
      checkOutput("reset zero done", 128'(zDone), 128'(0));
      pushCopy();
      rst_i = 1'b1;
   endtask

   task automatic checkFinished(input string tag, input int doneAt, input bit ok, input int expDone);
      checkOutput({tag, " done reached"}, 128'(ok), 128'(1));
      checkOutput({tag, " done cycle"}, 128'(doneAt), 128'(expDone));
      checkOutput({tag, " cpu_rst"}, 128'(cpuRst), 128'(0));
      checkOutput({tag, " busy"}, 128'(busy), 128'(0));
      checkOutput({tag, " err"}, 128'(err), 128'(0));
      checkOutput({tag, " count"}, 128'(count), 128'(4));
      checkOutput({tag, " writes left"}, 128'(expQ.size()), 128'(0));
   endtask

   runVec_t runs[3];

   initial begin
      int doneAt;
      bit ok;
      int s;
      int c0;

      runs[0] = '{waits: 0, expDone: 25};
      runs[1] = '{waits: 3, expDone: 49};
      runs[2] = '{waits: 1, expDone: 33};

      for (int r = 0; r < 3; r++) begin
         applyStimulus(runs[r].waits);
         waitCycle(1);
         checkOutput("busy at clock 1", 128'(busy), 128'(1));
         checkOutput("zero done at clock 1", 128'(zDone), 128'(1));
         checkOutput("zero cpu_rst at clock 1", 128'(zCpuRst), 128'(0));
         waitCycle(8);
`ifdef BOOT_COPIER_TIMEOUT_EN
         checkOutput("timeout err at clock 8", 128'(tErr), 128'(0));
         waitCycle(9);
         checkOutput("timeout err at clock 9", 128'(tErr), 128'(1));
         checkOutput("timeout cyc", 128'(tCyc), 128'(0));
         checkOutput("timeout cpu_rst", 128'(tCpuRst), 128'(1));
         checkOutput("timeout done", 128'(tDone), 128'(0));
`else
         waitCycle(9);
         checkOutput("no-timeout err", 128'(tErr), 128'(0));
         checkOutput("no-timeout cyc", 128'(tCyc), 128'(1));
         checkOutput("no-timeout busy", 128'(tBusy), 128'(1));
`endif
         waitDone(doneAt, ok);
         checkFinished("run", doneAt, ok, runs[r].expDone);
         checkOutput("zero never cycled", 128'(zCycSeen), 128'(0));
      end

      // Reset while writing word index 1: bus drops asynchronously, copy restarts at word 0
      applyStimulus(0);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_i);
         if (we && stb && count == 16'd1) ok = 1'b1;
      end
      checkOutput("reached write 2", 128'(ok), 128'(1));
      #1 rst_i = 1'b0;
      #1;
      checkOutput("async reset cyc", 128'(cyc), 128'(0));
      checkOutput("async reset stb", 128'(stb), 128'(0));
      checkOutput("async reset cpu_rst", 128'(cpuRst), 128'(1));
      checkOutput("async reset count", 128'(count), 128'(0));
      applyStimulus(0);
      waitDone(doneAt, ok);
      checkFinished("after reset", doneAt, ok, 25);

      // start_i after done re-runs the copy; start_i mid-copy is ignored
      @(negedge clk_i);
      pushCopy();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      s = cycleCnt;
      checkOutput("restart done cleared", 128'(done), 128'(0));
      checkOutput("restart busy", 128'(busy), 128'(1));
      checkOutput("restart cpu_rst", 128'(cpuRst), 128'(1));
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_i);
         if (count == 16'd2) ok = 1'b1;
      end
      checkOutput("reached count 2", 128'(ok), 128'(1));
      c0 = int'(count);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("count monotonic", 128'(int'(count) >= c0), 128'(1));
      checkOutput("busy kept", 128'(busy), 128'(1));
      waitDone(doneAt, ok);
      checkFinished("restart", doneAt - s, ok, 24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
